// File: rtl/rv32e_pkg.sv
// Shared encodings for the rv32e multi-cycle control path.
// RV32E_CSR_EN adds the CSR state to ctrl_state_t.
package rv32e_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
`ifdef RV32E_CSR_EN
      ST_CSR,
`endif
      ST_HALT
   } ctrl_state_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_CSR = 2'd3
   } wb_sel_t;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_IMM   = 2'd1,
      PC_JALR  = 2'd2
   } pc_src_t;

   // RV32E has 16 registers, so bit 4 of any register field that is read or written is illegal.
   function automatic logic instr_legal(input logic [6:0] opc,
                                        input logic [2:0] funct3,
                                        input logic       rd_b4,
                                        input logic       rs1_b4,
                                        input logic       rs2_b4,
                                        input logic       csr_en);
      logic ok;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL:  ok = !rd_b4;
         OPC_JALR, OPC_LOAD, OPC_IMM:  ok = !rd_b4 && !rs1_b4;
         OPC_BRANCH, OPC_STORE:        ok = !rs1_b4 && !rs2_b4;
         OPC_OP:                       ok = !rd_b4 && !rs1_b4 && !rs2_b4;
         // funct3[2] selects the CSR immediate forms, where the rs1 field is a uimm.
         OPC_SYSTEM:                   ok = csr_en && (funct3 != 3'd0) && !rd_b4 &&
                                            (funct3[2] || !rs1_b4);
         default:                      ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/rv32e_mem_watchdog.sv
// Memory-wait watchdog: counts stalled cycles and flags the cycle in which the
// MEM_TIMEOUT-th consecutive wait occurs. MEM_TIMEOUT = 0 disables it.
module rv32e_mem_watchdog #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_timeout
);

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [CW-1:0] r_count;

   assign o_timeout = (MEM_TIMEOUT != 0) && i_en && (r_count == LIMIT);

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && !o_timeout) begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/rv32e_mc_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the rv32e core.
// Optional RV32E_CSR_EN builds the CSR writeback state; otherwise SYSTEM is illegal.
module rv32e_mc_ctrl
   import rv32e_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        alu_b_imm,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        csr_we,
   output logic        retire_o,
   output logic        illegal_o,
   output logic        bus_err_o,
   output logic        halt_o
);

`ifdef RV32E_CSR_EN
   localparam logic CSR_EN = 1'b1;
`else
   localparam logic CSR_EN = 1'b0;
`endif

   ctrl_state_t r_state;
   logic        r_mem_req;
   logic        r_mem_addr_sel;
   logic        r_mem_we;
   logic        r_halt;
   logic        r_illegal;
   logic        r_bus_err;

   logic [6:0]  w_opc;
   logic        w_legal;
   logic        w_b_imm;
   logic        w_wait;
   logic        w_timeout;
   logic        w_unused_instr;

   assign w_opc   = instr[6:0];
   assign w_legal = instr_legal(w_opc, instr[14:12], instr[11], instr[19], instr[24], CSR_EN);
   assign w_b_imm = (w_opc != OPC_OP) && (w_opc != OPC_BRANCH);
   assign w_wait  = (r_state == ST_FETCH) || (r_state == ST_MEM);

   assign w_unused_instr = ^{instr[31:25], instr[23:20], instr[18:15], instr[10:7]};

   // A ready cycle ends the wait, so the next FETCH/MEM always starts from zero.
   rv32e_mem_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (!w_wait || mem_ready),
      .i_en      (w_wait && !mem_ready),
      .o_timeout (w_timeout)
   );

   assign mem_req      = r_mem_req;
   assign mem_addr_sel = r_mem_addr_sel;
   assign mem_we       = r_mem_we;
   assign halt_o       = r_halt;
   assign illegal_o    = r_illegal;
   assign bus_err_o    = r_bus_err;

   // Memory-port and status outputs are registered from the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_mem_req      <= 1'b0;
         r_mem_addr_sel <= 1'b0;
         r_mem_we       <= 1'b0;
         r_halt         <= 1'b0;
         r_illegal      <= 1'b0;
         r_bus_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state        <= ST_FETCH;
               r_mem_req      <= 1'b1;
               r_mem_addr_sel <= 1'b0;
               r_mem_we       <= 1'b0;
            end
            ST_FETCH: begin
               if (mem_ready) begin
                  r_state   <= ST_DECODE;
                  r_mem_req <= 1'b0;
               end else if (w_timeout) begin
                  r_state   <= ST_HALT;
                  r_mem_req <= 1'b0;
                  r_bus_err <= 1'b1;
                  r_halt    <= 1'b1;
               end
            end
            ST_DECODE: begin
               if (w_legal) begin
                  r_state <= ST_EXEC;
               end else begin
                  r_state   <= ST_HALT;
                  r_illegal <= 1'b1;
                  r_halt    <= 1'b1;
               end
            end
            ST_EXEC: begin
               case (w_opc)
                  OPC_BRANCH, OPC_JAL, OPC_JALR: begin
                     r_state        <= ST_FETCH;
                     r_mem_req      <= 1'b1;
                     r_mem_addr_sel <= 1'b0;
                     r_mem_we       <= 1'b0;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     r_state        <= ST_MEM;
                     r_mem_req      <= 1'b1;
                     r_mem_addr_sel <= 1'b1;
                     r_mem_we       <= (w_opc == OPC_STORE);
                  end
`ifdef RV32E_CSR_EN
                  OPC_SYSTEM: r_state <= ST_CSR;
`endif
                  default: r_state <= ST_WB;
               endcase
            end
            ST_MEM: begin
               if (mem_ready) begin
                  if (r_mem_we) begin
                     r_state <= ST_FETCH;
                  end else begin
                     r_state   <= ST_WB;
                     r_mem_req <= 1'b0;
                  end
                  r_mem_addr_sel <= 1'b0;
                  r_mem_we       <= 1'b0;
               end else if (w_timeout) begin
                  r_state        <= ST_HALT;
                  r_mem_req      <= 1'b0;
                  r_mem_addr_sel <= 1'b0;
                  r_mem_we       <= 1'b0;
                  r_bus_err      <= 1'b1;
                  r_halt         <= 1'b1;
               end
            end
`ifdef RV32E_CSR_EN
            ST_CSR,
`endif
            ST_WB: begin
               r_state        <= ST_FETCH;
               r_mem_req      <= 1'b1;
               r_mem_addr_sel <= 1'b0;
               r_mem_we       <= 1'b0;
            end
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Strobes that depend on same-cycle inputs (mem_ready, branch_taken) stay combinational.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = PC_PLUS4;
      alu_b_imm = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      retire_o  = 1'b0;
`ifdef RV32E_CSR_EN
      csr_we    = 1'b0;
`endif
      case (r_state)
         ST_FETCH:  ir_we = mem_ready;
         ST_DECODE: alu_b_imm = w_b_imm;
         ST_EXEC: begin
            alu_b_imm = w_b_imm;
            case (w_opc)
               OPC_BRANCH: begin
                  pc_we    = 1'b1;
                  pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
                  retire_o = 1'b1;
               end
               OPC_JAL, OPC_JALR: begin
                  rf_we    = 1'b1;
                  wb_sel   = WB_PC4;
                  pc_we    = 1'b1;
                  pc_src   = (w_opc == OPC_JAL) ? PC_IMM : PC_JALR;
                  retire_o = 1'b1;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            alu_b_imm = w_b_imm;
            if (r_mem_we && mem_ready) begin
               pc_we    = 1'b1;
               retire_o = 1'b1;
            end
         end
         ST_WB: begin
            alu_b_imm = w_b_imm;
            rf_we     = 1'b1;
            wb_sel    = (w_opc == OPC_LOAD) ? WB_MEM : WB_ALU;
            pc_we     = 1'b1;
            retire_o  = 1'b1;
         end
`ifdef RV32E_CSR_EN
         ST_CSR: begin
            alu_b_imm = w_b_imm;
            csr_we    = 1'b1;
            rf_we     = 1'b1;
            wb_sel    = WB_CSR;
            pc_we     = 1'b1;
            retire_o  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

`ifndef RV32E_CSR_EN
   assign csr_we = 1'b0;
`endif

endmodule

// File: tb/tb_rv32e_mc_ctrl.sv
// Directed bench for rv32e_mc_ctrl: each instruction is expanded into a per-cycle
// plan of inputs and expected outputs, then replayed and compared cycle by cycle.
module tb_rv32e_mc_ctrl;

   localparam int TIMEOUT = 8;
`ifdef RV32E_CSR_EN
   localparam bit CSR_EN = 1'b1;
`else
   localparam bit CSR_EN = 1'b0;
`endif

   localparam logic [31:0] JUNK   = 32'hFFFF_FFFF;
   localparam logic [31:0] ADDI   = 32'h0050_0093;
   localparam logic [31:0] ADDI16 = 32'h0050_0813;
   localparam logic [31:0] LW     = 32'h0000_A103;
   localparam logic [31:0] SW     = 32'h0020_A223;
   localparam logic [31:0] BEQ    = 32'h0000_0463;
   localparam logic [31:0] JAL    = 32'h0080_00EF;
   localparam logic [31:0] JALR   = 32'h0000_8067;
   localparam logic [31:0] LUI    = 32'h1234_52B7;
   localparam logic [31:0] ADD    = 32'h0020_81B3;
   localparam logic [31:0] AUIPC  = 32'h0000_1217;
   localparam logic [31:0] CSRRW  = 32'h3001_10F3;
   localparam logic [31:0] ECALL  = 32'h0000_0073;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        branch_taken;
   logic        mem_ready;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
   logic [1:0]  pc_src, wb_sel;
   logic        alu_b_imm, rf_we, csr_we, retire_o, illegal_o, bus_err_o, halt_o;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_sel;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       alu_b_imm;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       csr_we;
      logic       retire;
      logic       illegal;
      logic       bus_err;
      logic       halt;
   } out_t;

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        ready;
      logic        taken;
      out_t        exp;
      string       tag;
   } cyc_t;

   cyc_t plan[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   retire_cnt = 0;

   rv32e_mc_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_src       (pc_src),
      .alu_b_imm    (alu_b_imm),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .csr_we       (csr_we),
      .retire_o     (retire_o),
      .illegal_o    (illegal_o),
      .bus_err_o    (bus_err_o),
      .halt_o       (halt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   function automatic void push(input logic r, input logic [31:0] ins, input logic rdy,
                                input logic tk, input out_t e, input string tag);
      cyc_t c;
      c.rst = r; c.instr = ins; c.ready = rdy; c.taken = tk; c.exp = e; c.tag = tag;
      plan.push_back(c);
   endfunction

   // Register usage per opcode class; any used field with bit 4 set is illegal.
   function automatic bit model_legal(input logic [31:0] ins);
      bit [2:0] use_rd_rs1_rs2;
      case (ins[6:0])
         7'h37, 7'h17, 7'h6F: use_rd_rs1_rs2 = 3'b100;
         7'h67, 7'h03, 7'h13: use_rd_rs1_rs2 = 3'b110;
         7'h63, 7'h23:        use_rd_rs1_rs2 = 3'b011;
         7'h33:               use_rd_rs1_rs2 = 3'b111;
         7'h73: begin
            if (!CSR_EN || ins[14:12] == 3'd0) return 1'b0;
            use_rd_rs1_rs2 = {1'b1, !ins[14], 1'b0};
         end
         default: return 1'b0;
      endcase
      return !((use_rd_rs1_rs2[2] && ins[11]) || (use_rd_rs1_rs2[1] && ins[19]) ||
               (use_rd_rs1_rs2[0] && ins[24]));
   endfunction

   task automatic plan_reset(input int n);
      for (int i = 0; i < n; i++) push(1'b1, JUNK, 1'b1, 1'b1, '0, "reset");
      push(1'b0, JUNK, 1'b1, 1'b1, '0, "idle");
   endtask

   task automatic plan_halt(input logic ill, input logic be, input string nm);
      out_t e;
      e = '0; e.halt = 1'b1; e.illegal = ill; e.bus_err = be;
      for (int i = 0; i < 3; i++) push(1'b0, JUNK, 1'b1, 1'b1, e, {nm, "/halt"});
   endtask

   task automatic plan_instr(input logic [31:0] ins, input int fwait, input int mwait,
                             input logic tk, input int rst_at_mem, input string nm);
      out_t e;
      logic [6:0] opc;
      bit bimm;
      opc  = ins[6:0];
      bimm = (opc != 7'h33) && (opc != 7'h63);
      for (int i = 0; i < fwait; i++) begin
         e = '0; e.mem_req = 1'b1;
         push(1'b0, JUNK, 1'b0, tk, e, {nm, "/fetch_wait"});
         if (i + 1 == TIMEOUT) begin plan_halt(1'b0, 1'b1, nm); return; end
      end
      e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1;
      push(1'b0, JUNK, 1'b1, tk, e, {nm, "/fetch"});
      e = '0; e.alu_b_imm = bimm;
      push(1'b0, ins, 1'b1, tk, e, {nm, "/decode"});
      if (!model_legal(ins)) begin plan_halt(1'b1, 1'b0, nm); return; end
      e = '0; e.alu_b_imm = bimm;
      case (opc)
         7'h63: begin
            e.pc_we = 1'b1; e.pc_src = tk ? 2'd1 : 2'd0; e.retire = 1'b1;
            push(1'b0, ins, 1'b1, tk, e, {nm, "/exec"});
         end
         7'h6F, 7'h67: begin
            e.rf_we = 1'b1; e.wb_sel = 2'd2; e.pc_we = 1'b1; e.retire = 1'b1;
            e.pc_src = (opc == 7'h6F) ? 2'd1 : 2'd2;
            push(1'b0, ins, 1'b1, tk, e, {nm, "/exec"});
         end
         7'h03, 7'h23: begin
            push(1'b0, ins, 1'b1, tk, e, {nm, "/exec"});
            e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.alu_b_imm = 1'b1;
            e.mem_we = (opc == 7'h23);
            for (int i = 0; i < mwait; i++) begin
               if (i == rst_at_mem) begin
                  push(1'b1, ins, 1'b0, tk, '0, {nm, "/mem_rst"});
                  return;
               end
               push(1'b0, ins, 1'b0, tk, e, {nm, "/mem_wait"});
               if (i + 1 == TIMEOUT) begin plan_halt(1'b0, 1'b1, nm); return; end
            end
            if (opc == 7'h23) begin e.pc_we = 1'b1; e.retire = 1'b1; end
            push(1'b0, ins, 1'b1, tk, e, {nm, "/mem"});
            if (opc == 7'h03) begin
               e = '0; e.alu_b_imm = 1'b1; e.rf_we = 1'b1; e.wb_sel = 2'd1;
               e.pc_we = 1'b1; e.retire = 1'b1;
               push(1'b0, ins, 1'b1, tk, e, {nm, "/wb"});
            end
         end
         7'h73: begin
            push(1'b0, ins, 1'b1, tk, e, {nm, "/exec"});
            e = '0; e.alu_b_imm = 1'b1; e.csr_we = 1'b1; e.rf_we = 1'b1; e.wb_sel = 2'd3;
            e.pc_we = 1'b1; e.retire = 1'b1;
            push(1'b0, ins, 1'b1, tk, e, {nm, "/csr"});
         end
         default: begin
            push(1'b0, ins, 1'b1, tk, e, {nm, "/exec"});
            e = '0; e.alu_b_imm = bimm; e.rf_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
            push(1'b0, ins, 1'b1, tk, e, {nm, "/wb"});
         end
      endcase
   endtask

   initial begin
      int   len;
      out_t got;
      rst = 1'b0; instr = JUNK; mem_ready = 1'b0; branch_taken = 1'b0;
      #1 rst = 1'b1;

      plan_reset(2);
      len = plan.size(); plan_instr(ADDI, 0, 0, 1'b0, -1, "addi");
      check("model_len_alu", plan.size() - len, 4);
      len = plan.size(); plan_instr(LW, 0, 3, 1'b0, -1, "lw_late3");
      check("model_len_lw_late3", plan.size() - len, 8);
      len = plan.size(); plan_instr(BEQ, 0, 0, 1'b1, -1, "beq_taken");
      check("model_len_branch", plan.size() - len, 3);
      plan_instr(BEQ, 0, 0, 1'b0, -1, "beq_not_taken");
      len = plan.size(); plan_instr(SW, 0, 0, 1'b0, -1, "sw");
      check("model_len_store", plan.size() - len, 4);
      len = plan.size(); plan_instr(JAL, 0, 0, 1'b0, -1, "jal");
      check("model_len_jump", plan.size() - len, 3);
      plan_instr(JALR, 0, 0, 1'b1, -1, "jalr");
      plan_instr(LUI, 0, 0, 1'b0, -1, "lui");
      plan_instr(ADD, 0, 0, 1'b1, -1, "add");
      plan_instr(AUIPC, 0, 0, 1'b0, -1, "auipc");
      plan_instr(CSRRW, 0, 0, 1'b0, -1, "csrrw");
      plan_reset(1);
      check("model_legal_x16", int'(model_legal(ADDI16)), 0);
      check("model_legal_csrrw", int'(model_legal(CSRRW)), int'(CSR_EN));
      plan_instr(ADDI16, 0, 0, 1'b0, -1, "addi_x16");
      plan_reset(1);
      plan_instr(ADDI, TIMEOUT, 0, 1'b0, -1, "fetch_timeout");
      plan_reset(1);
      plan_instr(LW, 0, TIMEOUT, 1'b0, -1, "mem_timeout");
      plan_reset(1);
      plan_instr(ADDI, TIMEOUT - 1, 0, 1'b0, -1, "fetch_ready_at_limit");
      plan_instr(LW, 0, 2, 1'b0, 1, "lw_rst_mid_mem");
      plan_reset(1);
      plan_instr(SW, 0, 5, 1'b0, -1, "sw_wait5");
      plan_instr(ADDI, TIMEOUT - 1, 0, 1'b0, -1, "addi_after_sw");
      plan_instr(ECALL, 0, 0, 1'b0, -1, "ecall");
      plan_reset(1);

      foreach (plan[k]) begin
         @(negedge clk);
         rst          = plan[k].rst;
         instr        = plan[k].instr;
         mem_ready    = plan[k].ready;
         branch_taken = plan[k].taken;
         #2;
         got = out_t'({mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_b_imm,
                       rf_we, wb_sel, csr_we, retire_o, illegal_o, bus_err_o, halt_o});
         n_cmp++;
         if (got !== plan[k].exp) begin
            n_fail++;
            $display("FAIL %s [cycle %0d]: got %b want %b", plan[k].tag, k, got, plan[k].exp);
         end
         if (retire_o === 1'b1) retire_cnt++;
      end

      check("retire_total", retire_cnt, 13 + int'(CSR_EN));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
